branch_ctrl: RTL and testbench
==============================

# branch_ctrl

Sequencer for the ID-stage branch unit. Decides when a branch in ID may resolve: it stalls on operand hazards that forwarding cannot cover. It holds a taken-branch target until the delay-slot instruction has been fetched, then issues a valid/ready PC redirect to the fetch stage. It sits between the ID-stage branch unit, the pipeline hazard signals and the IF stage, and also keeps two performance counters.

## Interface
Parameters:
- none. Widths come from `W_ADDR` (32) and `W_REG` (5) in defines.vh.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  exception/eret flush; drops everything pending
- id_valid  in  1  ID holds a valid instruction
- id_is_br  in  1  ID instruction is a branch/jump (any branch oper)
- id_use_rs, id_use_rt  in  1 each  branch reads rs / rt
- id_rs, id_rt  in  `W_REG`  source register numbers
- br_taken  in  1  branch unit `branch` output
- br_addr  in  `W_ADDR`  branch unit target
- ex_wen  in  1  EX stage writes a register (result not forwardable to ID)
- ex_waddr  in  `W_REG`  EX destination
- mem_load  in  1  MEM stage holds a load (data not yet available)
- mem_waddr  in  `W_REG`  MEM destination
- slot_fetched  in  1  delay-slot instruction accepted by IF this cycle
- redir_ready  in  1  IF accepts a redirect this cycle
- id_stall  out  1  hold ID/IF, combinational
- redir_valid  out  1  redirect request, registered
- redir_addr  out  `W_ADDR`  redirect target, registered
- br_count  out  32  accepted taken branches
- stall_count  out  32  cycles id_stall was high

## Operation
- Hazard (combinational): `haz = id_valid & id_is_br & ((id_use_rs & match(id_rs)) | (id_use_rt & match(id_rt)))`.
  - `match(r) = r != 0 & ((ex_wen & ex_waddr == r) | (mem_load & mem_waddr == r))`.
- `busy = state != IDLE`.
- `id_stall = haz | (busy & id_valid & id_is_br)`. A branch in a delay slot waits until the redirect completes.
- Accept: `acc = id_valid & id_is_br & ~id_stall & br_taken & ~flush`. Not-taken branches need no state.
- FSM, states in priority order:
  - flush or rst: go to IDLE; clear redir_valid. Counters clear on rst only.
  - IDLE: on acc, latch br_addr into redir_addr.
    - If slot_fetched is high in the same cycle, go to REDIR.
    - Otherwise go to WAIT_SLOT.
  - WAIT_SLOT: on slot_fetched, go to REDIR.
  - REDIR: redir_valid=1. When redir_ready is high, go to IDLE.
- redir_valid and redir_addr are stable while redir_valid=1 and redir_ready=0. The address never changes mid-handshake.
- br_count increments on acc. stall_count increments every cycle id_stall=1. Both are 32-bit and wrap 0xFFFFFFFF→0.

## Timing
- Reset values: redir_valid=0, redir_addr=0, br_count=0, stall_count=0, state IDLE.
- id_stall has reset value 0 only if its inputs are idle (it is combinational).
- Accept at cycle T with slot_fetched=1 gives redir_valid=1 at T+1.
- Slot fetched at T+k gives redir_valid at T+k+1.
- Handshake completes in the cycle where redir_valid & redir_ready. redir_valid=0 the next cycle unless a new REDIR is entered.
- A new acc is impossible while busy, because id_stall blocks branches.
- flush in any cycle: state is IDLE and redir_valid=0 at the next edge. flush wins over a simultaneous acc, slot_fetched or redir_ready. A flushed redirect is never issued.
- A hazard stall lasts while `haz` holds: 1 cycle for an EX ALU producer, 1 cycle for a MEM load.

## Structure
- Shared package (mips_pkg): `branch_state_t` enum {IDLE, WAIT_SLOT, REDIR}.
- `W_ADDR` and `W_REG` stay in defines.vh.
- Sub-module `branch_hazard`: combinational; computes `haz` from the ID/EX/MEM register fields.
- The FSM and counters live in branch_ctrl.

## Test plan
- rs=5, ex_wen=1, ex_waddr=5, taken branch in ID -> id_stall=1 for 1 cycle, stall_count=1; accepted next cycle. Same case with id_rs=0 -> no stall.
- Taken branch br_addr=0xBFC00100 with slot_fetched=1 at T, redir_ready=1 -> redir_valid=1 only at T+1, redir_addr=0xBFC00100, br_count=1.
- slot_fetched delayed 3 cycles, redir_ready low 2 cycles -> WAIT_SLOT 3 cycles; redir_valid high 2 cycles with a constant address; drops after the handshake.
- Second branch in ID while in REDIR -> id_stall=1 until the handshake; then accepted with its own target.
- flush during REDIR with redir_ready=0 -> redir_valid=0 next cycle; no redirect observed. flush coincident with acc -> state stays IDLE, br_count unchanged.
- Preload stall_count near 0xFFFFFFFF via a long hazard (forced) -> wraps to 0; rst mid-WAIT_SLOT -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared pipeline definitions: datapath widths and the branch sequencer state type.
`ifndef W_ADDR
`define W_ADDR 32
`endif
`ifndef W_REG
`define W_REG 5
`endif

package mips_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_SLOT = 2'd1,
    REDIR     = 2'd2
  } branch_state_t;

endpackage

// File: rtl/branch_hazard.sv
// Operand hazard detect for an ID-stage branch: flags sources that forwarding cannot
// supply yet (an EX-stage result or a MEM-stage load).
module branch_hazard
  import mips_pkg::*;
(
  input  logic              id_valid,
  input  logic              id_is_br,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [`W_REG-1:0] id_rs,
  input  logic [`W_REG-1:0] id_rt,
  input  logic              ex_wen,
  input  logic [`W_REG-1:0] ex_waddr,
  input  logic              mem_load,
  input  logic [`W_REG-1:0] mem_waddr,
  output logic              haz
);

  // Register 0 is hardwired, so it never carries a dependence.
  function automatic logic f_match(
    input logic [`W_REG-1:0] r,
    input logic              ex_we,
    input logic [`W_REG-1:0] ex_wa,
    input logic              mem_ld,
    input logic [`W_REG-1:0] mem_wa
  );
    return (r != '0) && ((ex_we && (ex_wa == r)) || (mem_ld && (mem_wa == r)));
  endfunction

  logic w_rs_hit;
  logic w_rt_hit;

  assign w_rs_hit = id_use_rs && f_match(id_rs, ex_wen, ex_waddr, mem_load, mem_waddr);
  assign w_rt_hit = id_use_rt && f_match(id_rt, ex_wen, ex_waddr, mem_load, mem_waddr);
  assign haz      = id_valid && id_is_br && (w_rs_hit || w_rt_hit);

endmodule

// File: rtl/branch_ctrl.sv
// ID-stage branch sequencer: stalls on unforwardable operands, holds a taken target
// until the delay slot is fetched, then issues a valid/ready redirect to IF.
module branch_ctrl
  import mips_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               id_valid,
  input  logic               id_is_br,
  input  logic               id_use_rs,
  input  logic               id_use_rt,
  input  logic [`W_REG-1:0]  id_rs,
  input  logic [`W_REG-1:0]  id_rt,
  input  logic               br_taken,
  input  logic [`W_ADDR-1:0] br_addr,
  input  logic               ex_wen,
  input  logic [`W_REG-1:0]  ex_waddr,
  input  logic               mem_load,
  input  logic [`W_REG-1:0]  mem_waddr,
  input  logic               slot_fetched,
  input  logic               redir_ready,
  output logic               id_stall,
  output logic               redir_valid,
  output logic [`W_ADDR-1:0] redir_addr,
  output logic [31:0]        br_count,
  output logic [31:0]        stall_count
);

  branch_state_t      r_state;
  branch_state_t      w_next;
  logic               r_redir_valid;
  logic [`W_ADDR-1:0] r_redir_addr;
  logic [31:0]        r_br_count;
  logic [31:0]        r_stall_count;
  logic               w_haz;
  logic               w_busy;
  logic               w_stall;
  logic               w_acc;

  branch_hazard u_hazard (
    .id_valid  (id_valid),
    .id_is_br  (id_is_br),
    .id_use_rs (id_use_rs),
    .id_use_rt (id_use_rt),
    .id_rs     (id_rs),
    .id_rt     (id_rt),
    .ex_wen    (ex_wen),
    .ex_waddr  (ex_waddr),
    .mem_load  (mem_load),
    .mem_waddr (mem_waddr),
    .haz       (w_haz)
  );

  // A branch sitting in the delay slot must wait until the pending redirect drains.
  assign w_busy  = (r_state != IDLE);
  assign w_stall = w_haz || (w_busy && id_valid && id_is_br);
  assign w_acc   = id_valid && id_is_br && !w_stall && br_taken && !flush;

  always_comb begin
    w_next = r_state;
    if (flush) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:      if (w_acc) w_next = slot_fetched ? REDIR : WAIT_SLOT;
        WAIT_SLOT: if (slot_fetched) w_next = REDIR;
        REDIR:     if (redir_ready) w_next = IDLE;
        default:   w_next = IDLE;
      endcase
    end
  end

  // Target is captured only on accept, so it cannot move during a handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_redir_valid <= 1'b0;
      r_redir_addr  <= '0;
      r_br_count    <= '0;
      r_stall_count <= '0;
    end else begin
      r_state       <= w_next;
      r_redir_valid <= (w_next == REDIR);
      if (w_acc) r_redir_addr <= br_addr;
      r_br_count    <= r_br_count + {31'd0, w_acc};
      r_stall_count <= r_stall_count + {31'd0, w_stall};
    end
  end

  assign id_stall    = w_stall;
  assign redir_valid = r_redir_valid;
  assign redir_addr  = r_redir_addr;
  assign br_count    = r_br_count;
  assign stall_count = r_stall_count;

endmodule

// File: tb/tb_branch_ctrl.sv
// Bench for branch_ctrl: directed scenarios plus a randomized run against a
// pending-redirect reference model.
`ifndef W_ADDR
`define W_ADDR 32
`endif
`ifndef W_REG
`define W_REG 5
`endif

module tb_branch_ctrl;

  logic               clk;
  logic               rst, flush;
  logic               id_valid, id_is_br, id_use_rs, id_use_rt;
  logic [`W_REG-1:0]  id_rs, id_rt, ex_waddr, mem_waddr;
  logic               br_taken, ex_wen, mem_load, slot_fetched, redir_ready;
  logic [`W_ADDR-1:0] br_addr;
  logic               id_stall, redir_valid;
  logic [`W_ADDR-1:0] redir_addr;
  logic [31:0]        br_count, stall_count;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Reference model: a pending redirect (target + whether the slot was seen).
  bit          m_have, m_slot;
  logic [31:0] m_addr, m_br, m_st;

  branch_ctrl dut (
    .clk(clk), .rst(rst), .flush(flush),
    .id_valid(id_valid), .id_is_br(id_is_br), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_rs(id_rs), .id_rt(id_rt), .br_taken(br_taken), .br_addr(br_addr),
    .ex_wen(ex_wen), .ex_waddr(ex_waddr), .mem_load(mem_load), .mem_waddr(mem_waddr),
    .slot_fetched(slot_fetched), .redir_ready(redir_ready),
    .id_stall(id_stall), .redir_valid(redir_valid), .redir_addr(redir_addr),
    .br_count(br_count), .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit mm(input logic [`W_REG-1:0] r);
    return (r != 0) && ((ex_wen && ex_waddr == r) || (mem_load && mem_waddr == r));
  endfunction

  function automatic bit model_stall();
    bit hz;
    hz = id_valid && id_is_br && ((id_use_rs && mm(id_rs)) || (id_use_rt && mm(id_rt)));
    return hz || (m_have && id_valid && id_is_br);
  endfunction

  task automatic idle_inputs();
    flush = 0; id_valid = 0; id_is_br = 0; id_use_rs = 0; id_use_rt = 0;
    id_rs = 0; id_rt = 0; br_taken = 0; br_addr = 0; ex_wen = 0; ex_waddr = 0;
    mem_load = 0; mem_waddr = 0; slot_fetched = 0; redir_ready = 0;
  endtask

  task automatic branch(input logic [31:0] a, input logic slot);
    id_valid = 1; id_is_br = 1; br_taken = 1; br_addr = a; slot_fetched = slot;
  endtask

  // One clock: the model advances on the same edge as the DUT.
  task automatic tick();
    bit s, a;
    s = model_stall();
    a = !s && id_valid && id_is_br && br_taken && !flush;
    @(posedge clk);
    if (rst) begin
      m_have = 0; m_slot = 0; m_addr = 0; m_br = 0; m_st = 0;
    end else begin
      m_st = m_st + (s ? 1 : 0);
      m_br = m_br + (a ? 1 : 0);
      if (flush) begin
        m_have = 0; m_slot = 0;
      end else if (m_have) begin
        if (!m_slot) m_slot = slot_fetched;
        else if (redir_ready) begin m_have = 0; m_slot = 0; end
      end else if (a) begin
        m_have = 1; m_addr = br_addr; m_slot = slot_fetched;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    idle_inputs(); rst = 1; tick(); tick(); rst = 0; #1;
    vectors++; if (redir_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %0b want 0", redir_valid); end
    vectors++; if (redir_addr !== 32'd0) begin miscompares++; $display("FAIL reset_addr got %h want 0", redir_addr); end
    vectors++; if (br_count !== 32'd0) begin miscompares++; $display("FAIL reset_br_count got %0d want 0", br_count); end
    vectors++; if (stall_count !== 32'd0) begin miscompares++; $display("FAIL reset_stall_count got %0d want 0", stall_count); end
    vectors++; if (id_stall !== 1'b0) begin miscompares++; $display("FAIL reset_id_stall got %0b want 0", id_stall); end
  endtask

  task automatic test_hazard();
    idle_inputs(); branch(32'h0000_1000, 1); id_use_rs = 1; id_rs = 5; ex_wen = 1; ex_waddr = 5; #1;
    vectors++; if (id_stall !== 1'b1) begin miscompares++; $display("FAIL haz_stall got %0b want 1", id_stall); end
    tick(); ex_wen = 0; #1;
    vectors++; if (id_stall !== 1'b0) begin miscompares++; $display("FAIL haz_release got %0b want 0", id_stall); end
    vectors++; if (stall_count !== 32'd1) begin miscompares++; $display("FAIL haz_stall_count got %0d want 1", stall_count); end
    tick();
    vectors++; if (br_count !== 32'd1) begin miscompares++; $display("FAIL haz_br_count got %0d want 1", br_count); end
    vectors++; if (redir_valid !== 1'b1) begin miscompares++; $display("FAIL haz_redir got %0b want 1", redir_valid); end
    idle_inputs(); redir_ready = 1; tick();
    vectors++; if (redir_valid !== 1'b0) begin miscompares++; $display("FAIL haz_redir_drop got %0b want 0", redir_valid); end
    idle_inputs(); id_valid = 1; id_is_br = 1; id_use_rs = 1; id_rs = 0; ex_wen = 1; ex_waddr = 0; #1;
    vectors++; if (id_stall !== 1'b0) begin miscompares++; $display("FAIL haz_r0_stall got %0b want 0", id_stall); end
    tick(); idle_inputs();
    vectors++; if (stall_count !== 32'd1) begin miscompares++; $display("FAIL haz_r0_count got %0d want 1", stall_count); end
  endtask

  task automatic test_redirect();
    idle_inputs(); branch(32'hBFC0_0100, 1); redir_ready = 1; #1;
    vectors++; if (redir_valid !== 1'b0) begin miscompares++; $display("FAIL redir_T got %0b want 0", redir_valid); end
    tick();
    vectors++; if (redir_valid !== 1'b1) begin miscompares++; $display("FAIL redir_T1 got %0b want 1", redir_valid); end
    vectors++; if (redir_addr !== 32'hBFC0_0100) begin miscompares++; $display("FAIL redir_addr got %h want bfc00100", redir_addr); end
    vectors++; if (br_count !== 32'd2) begin miscompares++; $display("FAIL redir_br_count got %0d want 2", br_count); end
    idle_inputs(); redir_ready = 1; tick();
    vectors++; if (redir_valid !== 1'b0) begin miscompares++; $display("FAIL redir_T2 got %0b want 0", redir_valid); end
  endtask

  task automatic test_wait_slot();
    idle_inputs(); branch(32'h8000_0040, 0); redir_ready = 1; tick();
    idle_inputs(); redir_ready = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++; if (redir_valid !== 1'b0) begin miscompares++; $display("FAIL wait_slot_%0d got %0b want 0", i, redir_valid); end
    end
    slot_fetched = 1; redir_ready = 0; tick(); slot_fetched = 0;
    vectors++; if (redir_valid !== 1'b1 || redir_addr !== 32'h8000_0040) begin miscompares++; $display("FAIL wait_redir1 got %0b/%h want 1/80000040", redir_valid, redir_addr); end
    tick();
    vectors++; if (redir_valid !== 1'b1 || redir_addr !== 32'h8000_0040) begin miscompares++; $display("FAIL wait_redir2 got %0b/%h want 1/80000040", redir_valid, redir_addr); end
    redir_ready = 1; tick();
    vectors++; if (redir_valid !== 1'b0) begin miscompares++; $display("FAIL wait_drop got %0b want 0", redir_valid); end
    vectors++; if (br_count !== 32'd3) begin miscompares++; $display("FAIL wait_br_count got %0d want 3", br_count); end
  endtask

  task automatic test_back_to_back();
    idle_inputs(); branch(32'h0000_2000, 1); tick();
    branch(32'h0000_3000, 1); redir_ready = 0; #1;
    vectors++; if (id_stall !== 1'b1) begin miscompares++; $display("FAIL b2b_stall1 got %0b want 1", id_stall); end
    tick();
    vectors++; if (redir_valid !== 1'b1 || redir_addr !== 32'h0000_2000) begin miscompares++; $display("FAIL b2b_hold got %0b/%h want 1/00002000", redir_valid, redir_addr); end
    redir_ready = 1; #1;
    vectors++; if (id_stall !== 1'b1) begin miscompares++; $display("FAIL b2b_stall2 got %0b want 1", id_stall); end
    tick();
    vectors++; if (redir_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_drop got %0b want 0", redir_valid); end
    redir_ready = 0; #1;
    vectors++; if (id_stall !== 1'b0) begin miscompares++; $display("FAIL b2b_release got %0b want 0", id_stall); end
    tick();
    vectors++; if (redir_valid !== 1'b1 || redir_addr !== 32'h0000_3000) begin miscompares++; $display("FAIL b2b_second got %0b/%h want 1/00003000", redir_valid, redir_addr); end
    vectors++; if (br_count !== 32'd5 || stall_count !== 32'd3) begin miscompares++; $display("FAIL b2b_counts got %0d/%0d want 5/3", br_count, stall_count); end
    idle_inputs(); redir_ready = 1; tick();
  endtask

  task automatic test_flush();
    idle_inputs(); branch(32'h0000_4000, 1); tick();
    idle_inputs(); flush = 1; tick(); flush = 0;
    vectors++; if (redir_valid !== 1'b0) begin miscompares++; $display("FAIL flush_redir got %0b want 0", redir_valid); end
    redir_ready = 1; slot_fetched = 1; tick();
    vectors++; if (redir_valid !== 1'b0) begin miscompares++; $display("FAIL flush_after got %0b want 0", redir_valid); end
    idle_inputs(); branch(32'h0000_5000, 1); flush = 1; tick();
    vectors++; if (redir_valid !== 1'b0 || br_count !== 32'd6) begin miscompares++; $display("FAIL flush_acc got %0b/%0d want 0/6", redir_valid, br_count); end
    idle_inputs(); slot_fetched = 1; tick();
    vectors++; if (redir_valid !== 1'b0 || redir_addr !== 32'h0000_4000) begin miscompares++; $display("FAIL flush_idle got %0b/%h want 0/00004000", redir_valid, redir_addr); end
  endtask

  task automatic test_rst_mid();
    idle_inputs(); branch(32'h0000_6000, 0); tick();
    idle_inputs(); rst = 1; tick(); rst = 0;
    vectors++; if (redir_valid !== 1'b0 || redir_addr !== 32'd0) begin miscompares++; $display("FAIL rst_mid_redir got %0b/%h want 0/0", redir_valid, redir_addr); end
    vectors++; if (br_count !== 32'd0 || stall_count !== 32'd0) begin miscompares++; $display("FAIL rst_mid_counts got %0d/%0d want 0/0", br_count, stall_count); end
    slot_fetched = 1; tick();
    vectors++; if (redir_valid !== 1'b0) begin miscompares++; $display("FAIL rst_mid_slot got %0b want 0", redir_valid); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      rst          = ($urandom_range(0, 199) == 0);
      flush        = ($urandom_range(0, 39) == 0);
      id_valid     = ($urandom_range(0, 9) < 7);
      id_is_br     = ($urandom_range(0, 9) < 6);
      id_use_rs    = $urandom_range(0, 1);
      id_use_rt    = $urandom_range(0, 1);
      id_rs        = `W_REG'($urandom_range(0, 3));
      id_rt        = `W_REG'($urandom_range(0, 3));
      br_taken     = ($urandom_range(0, 9) < 7);
      br_addr      = $urandom;
      ex_wen       = ($urandom_range(0, 3) == 0);
      ex_waddr     = `W_REG'($urandom_range(0, 3));
      mem_load     = ($urandom_range(0, 3) == 0);
      mem_waddr    = `W_REG'($urandom_range(0, 3));
      slot_fetched = $urandom_range(0, 1);
      redir_ready  = $urandom_range(0, 1);
      #1;
      vectors++; if (id_stall !== model_stall()) begin miscompares++; $display("FAIL rnd_stall n=%0d got %0b want %0b", n, id_stall, model_stall()); end
      tick();
      vectors++; if (redir_valid !== (m_have && m_slot)) begin miscompares++; $display("FAIL rnd_valid n=%0d got %0b want %0b", n, redir_valid, m_have && m_slot); end
      vectors++; if (redir_addr !== m_addr) begin miscompares++; $display("FAIL rnd_addr n=%0d got %h want %h", n, redir_addr, m_addr); end
      vectors++; if (br_count !== m_br || stall_count !== m_st) begin miscompares++; $display("FAIL rnd_counts n=%0d got %0d/%0d want %0d/%0d", n, br_count, stall_count, m_br, m_st); end
    end
    rst = 0; idle_inputs();
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    m_have = 0; m_slot = 0; m_addr = 0; m_br = 0; m_st = 0;
    test_reset();
    test_hazard();
    test_redirect();
    test_wait_slot();
    test_back_to_back();
    test_flush();
    test_rst_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
